// File: rtl/sram_stream_reader_pkg.sv
// Shared types and constants for the SPI SRAM byte-stream reader.
package sram_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    GAP   = 2'd2,
    DRAIN = 2'd3
  } state_e;

  localparam logic [2:0]  CTI_CLASSIC        = 3'b000;
  localparam logic [1:0]  BTE_LINEAR         = 2'b00;
  localparam int unsigned DEFAULT_FIFO_DEPTH = 4;

endpackage

// File: rtl/sram_stream_reader_fifo.sv
// First-word-fall-through FIFO of {last, data} entries with synchronous flush.
module byte_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       flush_i,
  input  logic       push_i,
  input  logic [8:0] push_data_i,
  input  logic       pop_i,
  output logic [8:0] head_o,
  output logic       empty_o,
  output logic       full_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [8:0]  r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        w_push;
  logic        w_pop;

  // Extra MSB distinguishes full from empty when the index bits match.
  assign empty_o = (r_wr_ptr == r_rd_ptr);
  assign full_o  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  assign w_push = push_i & ~full_o & ~flush_i;
  assign w_pop  = pop_i & ~empty_o & ~flush_i;

  assign head_o = empty_o ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/sram_stream_reader.sv
// Wishbone master reading a contiguous byte run from SPI SRAM into a valid/ready stream.
module sram_stream_reader
  import sram_stream_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [23:0]          base_adr_i,
  input  logic [LEN_WIDTH-1:0] length_i,
  input  logic                 abort_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic                 cyc_o,
  output logic                 stb_o,
  output logic [23:0]          adr_o,
  output logic                 we_o,
  output logic [7:0]           dat_o,
  output logic [2:0]           cti_o,
  output logic [1:0]           bte_o,
  input  logic                 ack_i,
  input  logic                 err_i,
  input  logic                 rty_i,
  input  logic [7:0]           dat_i,
  output logic                 m_valid_o,
  output logic [7:0]           m_data_o,
  output logic                 m_last_o,
  input  logic                 m_ready_i
);

  state_e               r_state;
  state_e               w_state_nxt;
  logic [23:0]          r_adr;
  logic [LEN_WIDTH-1:0] r_rem;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_err;
  logic                 r_stb;

  logic                 w_capture;
  logic                 w_advance;
  logic                 w_flush;
  logic                 w_set_err;
  logic                 w_done_nxt;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic [8:0]           w_head;

  assign w_pop = ~w_empty & m_ready_i;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (w_flush),
    .push_i      (w_advance),
    .push_data_i ({(r_rem == LEN_WIDTH'(1)), dat_i}),
    .pop_i       (w_pop),
    .head_o      (w_head),
    .empty_o     (w_empty),
    .full_o      (w_full)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_advance   = 1'b0;
    w_flush     = 1'b0;
    w_set_err   = 1'b0;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start_i) begin
          w_capture = 1'b1;
          if (length_i == '0)  w_done_nxt  = 1'b1;
          else if (!w_full)    w_state_nxt = REQ;
          else                 w_state_nxt = GAP;
        end
      end
      REQ: begin
        // Abort outranks every termination, so a coincident ack is dropped.
        if (abort_i) begin
          w_state_nxt = IDLE;
          w_flush     = 1'b1;
        end else if (err_i) begin
          w_state_nxt = IDLE;
          w_flush     = 1'b1;
          w_set_err   = 1'b1;
        end else if (ack_i) begin
          w_advance   = 1'b1;
          w_state_nxt = (r_rem == LEN_WIDTH'(1)) ? DRAIN : GAP;
        end else if (rty_i) begin
          w_state_nxt = GAP;
        end
      end
      GAP: begin
        if (abort_i) begin
          w_state_nxt = IDLE;
          w_flush     = 1'b1;
        end else if (!w_full) begin
          w_state_nxt = REQ;
        end
      end
      DRAIN: begin
        if (abort_i) begin
          w_state_nxt = IDLE;
          w_flush     = 1'b1;
        end else if (w_pop && w_head[8]) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_adr   <= '0;
      r_rem   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_stb   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      r_stb   <= (w_state_nxt == REQ);
      r_done  <= w_done_nxt;
      if (w_capture) begin
        r_adr <= base_adr_i;
        r_rem <= length_i;
        r_err <= 1'b0;
      end
      if (w_advance) begin
        r_adr <= r_adr + 24'd1;
        r_rem <= r_rem - LEN_WIDTH'(1);
      end
      if (w_set_err) r_err <= 1'b1;
    end
  end

  assign busy_o    = r_busy;
  assign done_o    = r_done;
  assign err_o     = r_err;
  assign cyc_o     = r_stb;
  assign stb_o     = r_stb;
  assign adr_o     = r_adr;
  assign we_o      = 1'b0;
  assign dat_o     = '0;
  assign cti_o     = CTI_CLASSIC;
  assign bte_o     = BTE_LINEAR;
  assign m_valid_o = ~w_empty;
  assign m_data_o  = w_head[7:0];
  assign m_last_o  = w_head[8];

endmodule

// File: tb/tb_sram_stream_reader.sv
// Directed bench for sram_stream_reader with a behavioural Wishbone slave and stream monitor.
module tb_sram_stream_reader;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [23:0] base_adr_i;
  logic [15:0] length_i;
  logic        abort_i;
  logic        busy_o, done_o, err_o, cyc_o, stb_o, we_o;
  logic [23:0] adr_o;
  logic [7:0]  dat_o;
  logic [2:0]  cti_o;
  logic [1:0]  bte_o;
  logic        ack_i = 1'b0, err_i = 1'b0, rty_i = 1'b0;
  logic [7:0]  dat_i = 8'h00;
  logic        m_valid_o, m_last_o, m_ready_i;
  logic [7:0]  m_data_o;

  always #5 clk = ~clk;

  sram_stream_reader #(.FIFO_DEPTH(4), .LEN_WIDTH(16)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .base_adr_i(base_adr_i),
    .length_i(length_i), .abort_i(abort_i), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .cyc_o(cyc_o), .stb_o(stb_o), .adr_o(adr_o), .we_o(we_o),
    .dat_o(dat_o), .cti_o(cti_o), .bte_o(bte_o), .ack_i(ack_i), .err_i(err_i),
    .rty_i(rty_i), .dat_i(dat_i), .m_valid_o(m_valid_o), .m_data_o(m_data_o),
    .m_last_o(m_last_o), .m_ready_i(m_ready_i)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    logic [7:0] t;
    t = a[7:0] * 8'h11;
    return t + 8'hA1;
  endfunction

  // Slave: answers a strobe after slave_lat cycles; termination index picks ack/rty/err.
  bit          slave_auto = 1'b1;
  int          slave_lat  = 0;
  int          cfg_rty    = -1;
  int          cfg_err    = -1;
  int          term0      = 0;
  bit          man_ack    = 1'b0;
  logic [7:0]  man_dat    = 8'h00;
  int          term_cnt   = 0;
  int          wt         = 0;

  always @(negedge clk) begin
    if (!slave_auto) begin
      ack_i = man_ack; dat_i = man_dat; err_i = 1'b0; rty_i = 1'b0;
    end else if (ack_i || err_i || rty_i) begin
      ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0; wt = 0;
    end else if (stb_o) begin
      if (wt >= slave_lat) begin
        if (term_cnt - term0 == cfg_err)      err_i = 1'b1;
        else if (term_cnt - term0 == cfg_rty) rty_i = 1'b1;
        else begin ack_i = 1'b1; dat_i = mem_byte(adr_o); end
        term_cnt++;
        wt = 0;
      end else wt++;
    end else wt = 0;
  end

  // Monitor: request addresses, low-strobe gaps, popped bytes, done pulses.
  logic [23:0] adr_log [64];
  int          gap_log [64];
  logic [8:0]  rx [$];
  int          n_req = 0, done_cnt = 0, cyc_cnt = 0, low_cnt = 0;
  logic        prev_stb = 1'b0;

  always @(negedge clk) begin
    if (stb_o && !prev_stb && n_req < 64) begin
      adr_log[n_req] = adr_o;
      gap_log[n_req] = low_cnt;
      n_req++;
    end
    low_cnt  = stb_o ? 0 : low_cnt + 1;
    prev_stb = stb_o;
    if (cyc_o) cyc_cnt++;
    if (m_valid_o && m_ready_i) rx.push_back({m_last_o, m_data_o});
    if (done_o) done_cnt++;
  end

  int rx0, req0, done0, cyc0;

  task automatic do_start(input logic [23:0] b, input logic [15:0] l);
    @(posedge clk); #1;
    rx0 = rx.size(); req0 = n_req; done0 = done_cnt; cyc0 = cyc_cnt; term0 = term_cnt;
    start_i = 1'b1; base_adr_i = b; length_i = l;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (!busy_o) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: busy_o still 1 after %0d cycles, required 0", nm, max_cyc);
    end
  endtask

  typedef struct {
    logic [23:0] base;
    logic [15:0] len;
    int          rty_at;
    int          err_at;
    logic        exp_err;
    int          exp_done;
    int          exp_bytes;
    int          exp_reqs;
    bit          chk_gap;
  } vec_t;

  vec_t vecs [6];

  initial begin
    automatic vec_t v;
    automatic logic [23:0] ea;
    vecs[0] = '{24'h000100, 16'd3, -1, -1, 1'b0, 1, 3, 3, 1'b1};
    vecs[1] = '{24'hFFFFFF, 16'd2, -1, -1, 1'b0, 1, 2, 2, 1'b1};
    vecs[2] = '{24'h000200, 16'd4,  1, -1, 1'b0, 1, 4, 5, 1'b1};
    vecs[3] = '{24'h000300, 16'd5, -1,  2, 1'b1, 0, 2, 3, 1'b0};
    vecs[4] = '{24'h000400, 16'd1, -1, -1, 1'b0, 1, 1, 1, 1'b0};
    vecs[5] = '{24'h000500, 16'd0, -1, -1, 1'b0, 1, 0, 0, 1'b0};

    rst_ni = 1'b0; start_i = 1'b0; base_adr_i = '0; length_i = '0;
    abort_i = 1'b0; m_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cyc", cyc_o, 0);       chk("rst_stb", stb_o, 0);
    chk("rst_adr", adr_o, 0);       chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);     chk("rst_err", err_o, 0);
    chk("rst_valid", m_valid_o, 0); chk("rst_data", m_data_o, 0);
    chk("rst_last", m_last_o, 0);   chk("rst_we", we_o, 0);
    chk("rst_cti", cti_o, 0);       chk("rst_bte", bte_o, 0);
    @(posedge clk); #1 rst_ni = 1'b1;

    for (int r = 0; r < 6; r++) begin
      v = vecs[r];
      slave_lat = 0; cfg_rty = v.rty_at; cfg_err = v.err_at;
      do_start(v.base, v.len);
      wait_idle(200, $sformatf("r%0d_idle", r));
      repeat (3) @(negedge clk);
      chk($sformatf("r%0d_done", r), done_cnt - done0, v.exp_done);
      chk($sformatf("r%0d_err", r), err_o, v.exp_err);
      chk($sformatf("r%0d_nbytes", r), rx.size() - rx0, v.exp_bytes);
      chk($sformatf("r%0d_nreq", r), n_req - req0, v.exp_reqs);
      chk($sformatf("r%0d_valid_end", r), m_valid_o, 0);
      chk($sformatf("r%0d_cyc_seen", r), (cyc_cnt != cyc0), (v.exp_reqs > 0));
      for (int i = 0; i < v.exp_bytes && rx0 + i < rx.size(); i++)
        chk($sformatf("r%0d_byte%0d", r, i), rx[rx0 + i],
            {(i == int'(v.len) - 1), mem_byte(v.base + 24'(i))});
      for (int j = 0; j < v.exp_reqs && req0 + j < n_req; j++) begin
        ea = v.base + 24'(j) - ((v.rty_at >= 0 && j > v.rty_at) ? 24'd1 : 24'd0);
        chk($sformatf("r%0d_adr%0d", r, j), adr_log[req0 + j], ea);
      end
      if (v.chk_gap)
        for (int j = 1; j < v.exp_reqs && req0 + j < n_req; j++)
          chk($sformatf("r%0d_gap%0d", r, j), gap_log[req0 + j], 1);
    end

    // Consumer stalled: FIFO fills after four reads and the bus goes quiet.
    cfg_rty = -1; cfg_err = -1;
    m_ready_i = 1'b0;
    do_start(24'h000600, 16'd10);
    repeat (40) @(negedge clk);
    chk("stall_nreq", n_req - req0, 4);
    chk("stall_stb", stb_o, 0);
    chk("stall_busy", busy_o, 1);
    chk("stall_valid", m_valid_o, 1);
    @(posedge clk); #1 m_ready_i = 1'b1;
    wait_idle(300, "stall_idle");
    repeat (3) @(negedge clk);
    chk("stall_nbytes", rx.size() - rx0, 10);
    chk("stall_done", done_cnt - done0, 1);
    for (int i = 0; i < 10 && rx0 + i < rx.size(); i++)
      chk($sformatf("stall_byte%0d", i), rx[rx0 + i],
          {(i == 9), mem_byte(24'h000600 + 24'(i))});

    // Abort while the strobe is waiting on a slow slave.
    slave_lat = 5;
    do_start(24'h000700, 16'd4);
    for (int i = 0; i < 20 && !stb_o; i++) @(negedge clk);
    @(posedge clk); #1 abort_i = 1'b1;
    @(posedge clk); #1 abort_i = 1'b0;
    @(negedge clk);
    chk("abt_cyc", cyc_o, 0);
    chk("abt_stb", stb_o, 0);
    chk("abt_busy", busy_o, 0);
    chk("abt_valid", m_valid_o, 0);
    repeat (8) @(negedge clk);
    chk("abt_done", done_cnt - done0, 0);
    chk("abt_nbytes", rx.size() - rx0, 0);

    // Abort in the same cycle as an ack: the byte must be discarded.
    slave_lat = 0; slave_auto = 1'b0;
    do_start(24'h000800, 16'd4);
    for (int i = 0; i < 20 && !stb_o; i++) @(negedge clk);
    @(posedge clk); #1 man_ack = 1'b1; man_dat = 8'h77; abort_i = 1'b1;
    @(posedge clk); #1 man_ack = 1'b0; abort_i = 1'b0;
    @(negedge clk);
    chk("abtack_stb", stb_o, 0);
    chk("abtack_cyc", cyc_o, 0);
    chk("abtack_busy", busy_o, 0);
    chk("abtack_valid", m_valid_o, 0);
    repeat (5) @(negedge clk);
    chk("abtack_done", done_cnt - done0, 0);
    chk("abtack_nbytes", rx.size() - rx0, 0);
    slave_auto = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

endmodule
